// File: rtl/md_unit_if.sv
// Request/result bundle between the issue stage and the multiply/divide unit.
// The issuer (master) drives the request; the unit (slave) returns busy and HI/LO.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_in;
  logic [WIDTH-1:0] rt_in;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, rs_in, rt_in, input busy, hi, lo);
  modport slave  (input start, op, rs_in, rt_in, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Operands are captured at the start edge; results land on the edge where busy falls.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q;
  op_e              op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic               res_wr;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               is_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b, div_b, q_mag, r_mag;

  // Divide works on magnitudes so MIN_INT / -1 wraps to MIN_INT with remainder 0.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    ext_a     = {{WIDTH{is_signed & a_q[WIDTH-1]}}, a_q};
    ext_b     = {{WIDTH{is_signed & b_q[WIDTH-1]}}, b_q};
    prod      = ext_a * ext_b;

    a_neg = is_signed & a_q[WIDTH-1];
    b_neg = is_signed & b_q[WIDTH-1];
    mag_a = a_neg ? -a_q : a_q;
    mag_b = b_neg ? -b_q : b_q;
    div_b = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    q_mag = mag_a / div_b;
    r_mag = mag_a % div_b;

    res_wr = 1'b1;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_q == OP_DIV || op_q == OP_DIVU) begin
      res_wr = (b_q != '0);
      res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
      res_hi = a_neg ? -r_mag : r_mag;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md.start) begin
            case (op_e'(md.op))
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                a_q     <= md.rs_in;
                b_q     <= md.rt_in;
                op_q    <= op_e'(md.op);
                cnt_q   <= (md.op[1] == 1'b0) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                busy_q  <= 1'b1;
                state_q <= BUSY;
              end
              OP_MTHI: hi_q <= md.rs_in;
              OP_MTLO: lo_q <= md.rs_in;
              default: ;
            endcase
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (res_wr) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random ops against an
// arithmetic reference model of HI/LO.
module tb_md_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned NM = 5;
  localparam int unsigned ND = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(W)) md_bus ();

  md_unit #(.WIDTH(W), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {31'b0, md_bus.busy}, '0);
    check({tag, "_hi"}, md_bus.hi, m_hi);
    check({tag, "_lo"}, md_bus.lo, m_lo);
  endtask

  // Reference: plain 64-bit arithmetic on the operands.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          ps, qs, rs;
    longint unsigned pu;
    case (op)
      3'd0: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        m_hi = ps[63:32]; m_lo = ps[31:0];
      end
      3'd1: begin
        pu = 64'(a) * 64'(b);
        m_hi = pu[63:32]; m_lo = pu[31:0];
      end
      3'd2: if (b != 0) begin
        qs = longint'($signed(a)) / longint'($signed(b));
        rs = longint'($signed(a)) % longint'($signed(b));
        m_lo = qs[31:0]; m_hi = rs[31:0];
      end
      3'd3: if (b != 0) begin
        m_lo = a / b; m_hi = a % b;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Called at posedge+1: start edge is the next posedge. ign>=0 injects an
  // ignored start that many cycles into the busy window.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int ign);
    int n;
    n = (op < 3'd2) ? NM : ND;
    md_bus.start = 1'b1; md_bus.op = op; md_bus.rs_in = a; md_bus.rt_in = b;
    @(posedge clk); #1;
    md_bus.start = 1'b0; md_bus.rs_in = $urandom; md_bus.rt_in = $urandom;
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy_hi"}, {31'b0, md_bus.busy}, 32'd1);
      check({tag, "_hold_hi"}, md_bus.hi, m_hi);
      check({tag, "_hold_lo"}, md_bus.lo, m_lo);
      md_bus.start = (i == ign);
      md_bus.op    = 3'($urandom_range(0, 7));
      md_bus.rs_in = $urandom;
      md_bus.rt_in = $urandom;
      @(posedge clk); #1;
    end
    md_bus.start = 1'b0;
    model(op, a, b);
    check_idle(tag);
  endtask

  task automatic do_move(input string tag, input logic [2:0] op, input logic [W-1:0] a);
    md_bus.start = 1'b1; md_bus.op = op; md_bus.rs_in = a; md_bus.rt_in = $urandom;
    @(posedge clk); #1;
    md_bus.start = 1'b0;
    model(op, a, '0);
    check_idle(tag);
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    int           ign;

    reset = 1'b1;
    md_bus.start = 1'b0; md_bus.op = '0; md_bus.rs_in = '0; md_bus.rt_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    do_op("mult_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, -1);
    check("mult_hi_const", md_bus.hi, 32'hFFFF_FFFF);
    check("mult_lo_const", md_bus.lo, 32'hFFFF_FFFA);

    do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("multu_hi_const", md_bus.hi, 32'hFFFF_FFFE);
    check("multu_lo_const", md_bus.lo, 32'h0000_0001);

    do_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 2);
    check("div_lo_const", md_bus.lo, 32'hFFFF_FFFD);
    check("div_hi_const", md_bus.hi, 32'hFFFF_FFFF);

    do_move("mthi", 3'd4, 32'h1234);
    do_move("mtlo", 3'd5, 32'h5678);
    do_op("divu_by0", 3'd3, 32'hDEAD_BEEF, 32'd0, -1);
    check("div0_hi_const", md_bus.hi, 32'h1234);
    check("div0_lo_const", md_bus.lo, 32'h5678);

    do_move("mtlo_abcd", 3'd5, 32'hABCD);
    check("mtlo_const", md_bus.lo, 32'hABCD);
    do_op("div_minint", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("minint_lo_const", md_bus.lo, 32'h8000_0000);
    check("minint_hi_const", md_bus.hi, 32'h0);

    do_move("nop6", 3'd6, $urandom);
    do_move("nop7", 3'd7, $urandom);

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      ign = ($urandom_range(0, 1) == 1) ? $urandom_range(0, NM - 2) : -1;
      if (op < 3'd4) do_op("rand_op", op, a, b, ign);
      else           do_move("rand_move", op, a);
    end

    // Asynchronous reset in the second busy cycle of a mult.
    do_move("pre_rst", 3'd4, 32'h5555_AAAA);
    md_bus.start = 1'b1; md_bus.op = 3'd0; md_bus.rs_in = 32'h7; md_bus.rt_in = 32'h9;
    @(posedge clk); #1;
    md_bus.start = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    check_idle("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (NM + 3) @(posedge clk);
    #1;
    check_idle("post_rst");
    do_move("first_after_rst", 3'd4, 32'hCAFE_F00D);
    do_op("mult_after_rst", 3'd0, 32'd6, 32'hFFFF_FFF9, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 WIDTH, 32, operand and HI/LO register width in bits (≥ 4).
REQ-002 MULT_CYCLES, 5, busy duration for mult/multu (≥ 1).
REQ-003 DIV_CYCLES, 10, busy duration for div/divu (≥ 1).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 start  input  1  single-cycle request; samples op, rs_in and rt_in at the rising edge.
REQ-008 op  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op.
REQ-009 rs_in  input  WIDTH  operand A (dividend / multiplicand / move source), forwarded value from the E stage.
REQ-010 rt_in  input  WIDTH  operand B (divisor / multiplier).
REQ-011 busy  output  1  high while a mult/div operation is in flight.
REQ-012 hi  output  WIDTH  HI register.
REQ-013 lo  output  WIDTH  LO register.

Function
REQ-014 The state machine SHALL have two states: IDLE and BUSY.
REQ-015 IDLE, start with op 0-3: latch the operands, load the down-counter with MULT_CYCLES or DIV_CYCLES, go to BUSY, and assert busy from the next edge.
REQ-016 BUSY: decrement the counter each cycle; on the edge where the count reaches its end, write hi/lo, deassert busy and return to IDLE, so busy is high for exactly N cycles.
REQ-017 Result latency SHALL be N cycles after the start edge, with hi/lo changing on the same edge that busy falls.
REQ-018 IDLE, start with op 4/5: at that edge, write rs_in to hi/lo respectively; busy stays low and the other register is unchanged.
REQ-019 start received in BUSY, with any op, SHALL be ignored; hi, lo and the counter are unaffected (the hazard unit stalls D instead).
REQ-020 start with op 6/7 SHALL have no effect.
REQ-021 mult: {hi,lo} = signed(rs) × signed(rt), full 2×WIDTH product.
REQ-022 multu: {hi,lo} = the unsigned product, full 2×WIDTH.
REQ-023 div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-024 divu: lo = the unsigned quotient; hi = the unsigned remainder.
REQ-025 Divide by zero (div or divu) SHALL still run for DIV_CYCLES cycles but leave hi/lo unchanged.
REQ-026 div with MIN_INT / -1 SHALL give lo = MIN_INT and hi = 0.
REQ-027 hi and lo SHALL only change as stated in REQ-016 and REQ-018.
REQ-028 Operands SHALL be sampled only at the start edge; input changes during BUSY have no effect.

Reset
REQ-029 Asserting reset SHALL immediately, without waiting for clk, force hi = 0, lo = 0, busy = 0, state IDLE and counter 0.
REQ-030 Reset mid-operation SHALL abort the operation with no hi/lo update.
REQ-031 After reset deasserts, the first start edge SHALL be accepted normally.

Verification (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10)
REQ-032 mult with rs=0xFFFFFFFE (-2) and rt=3 -> busy high for exactly 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFA on the falling-busy edge.
REQ-033 multu with rs=0xFFFFFFFF and rt=0xFFFFFFFF -> hi=0xFFFFFFFE and lo=0x00000001 after 5 cycles.
REQ-034 div with rs=-7 and rt=2 -> after 10 cycles lo=0xFFFFFFFD (-3) and hi=0xFFFFFFFF (-1); a divu started in cycle 3 of that operation is ignored.
REQ-035 divu with rt=0, after mthi 0x1234 and mtlo 0x5678 -> busy for 10 cycles, then hi=0x1234 and lo=0x5678.
REQ-036 mtlo with rs=0xABCD -> lo=0xABCD at the next edge, busy never asserted; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 Reset asserted asynchronously during cycle 2 of a mult -> busy=0, hi=0 and lo=0 immediately, with no later update.
